// File: rtl/sub2_sched.sv
// Round-robin gather of three request bytes into a frame, issued to a shared sub2
// datapath; waits for done or timeout and returns the result on a valid/ready port.
module sub2_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_valid,
  input  logic [0:2][7:0] req_data,
  output logic [2:0]      req_ready,
  input  logic [1:0]      cfg_mode,
  output logic            sig_e,
  output logic [1:0]      sig_f,
  output logic [0:2][7:0] sig_g,
  output logic [7:0]      sig_h [0:2],
  input  logic            sig_i,
  input  logic [1:0]      sig_j,
  input  logic [0:2][7:0] sig_k,
  input  logic [7:0]      sig_l [0:2],
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [0:2][7:0] rsp_data,
  output logic [7:0]      rsp_tag [0:2],
  output logic [1:0]      rsp_status,
  output logic            timeout
);

  typedef enum logic [1:0] {StGather, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e          state_q;
  logic [1:0]      cnt_q;
  logic [1:0]      ptr_q;
  logic [7:0]      wcnt_q;
  logic            sig_e_q;
  logic [1:0]      sig_f_q;
  logic [0:2][7:0] sig_g_q;
  logic [7:0]      sig_h_q [0:2];
  logic            rsp_valid_q;
  logic [0:2][7:0] rsp_data_q;
  logic [7:0]      rsp_tag_q [0:2];
  logic [1:0]      rsp_status_q;
  logic            timeout_q;

  logic [1:0]      grant_id;
  logic [1:0]      lane;
  logic            found;
  logic            accept;

  function automatic logic [1:0] next_lane(input logic [1:0] l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction

  // Scan lanes starting just after the last grant; first valid lane wins.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    found     = 1'b0;
    lane      = next_lane(ptr_q);
    if (state_q == StGather) begin
      for (int i = 0; i < 3; i++) begin
        if (req_valid[lane] && !found) begin
          found           = 1'b1;
          req_ready[lane] = 1'b1;
          grant_id        = lane;
        end
        lane = next_lane(lane);
      end
    end
  end

  assign accept = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StGather;
      cnt_q        <= '0;
      ptr_q        <= 2'd2;
      wcnt_q       <= '0;
      sig_e_q      <= 1'b0;
      sig_f_q      <= '0;
      sig_g_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      timeout_q    <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        sig_h_q[k]   <= '0;
        rsp_tag_q[k] <= '0;
      end
    end else begin
      sig_e_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StGather: begin
          if (accept) begin
            sig_g_q[cnt_q] <= req_data[grant_id];
            sig_h_q[cnt_q] <= {6'b0, grant_id};
            ptr_q          <= grant_id;
            if (cnt_q == 2'd2) begin
              sig_f_q <= cfg_mode;
              cnt_q   <= '0;
              sig_e_q <= 1'b1;
              state_q <= StIssue;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        StIssue: begin
          wcnt_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // Done takes precedence over a timeout landing on the same cycle.
          if (sig_i) begin
            rsp_status_q <= sig_j;
            rsp_data_q   <= sig_k;
            rsp_tag_q    <= sig_l;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else if (wcnt_q == WaitLast) begin
            rsp_status_q <= 2'b11;
            rsp_data_q   <= '0;
            for (int k = 0; k < 3; k++) rsp_tag_q[k] <= '0;
            timeout_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            sig_g_q     <= '0;
            for (int k = 0; k < 3; k++) sig_h_q[k] <= '0;
            state_q     <= StGather;
          end
        end
        default: state_q <= StGather;
      endcase
    end
  end

  assign sig_e      = sig_e_q;
  assign sig_f      = sig_f_q;
  assign sig_g      = sig_g_q;
  assign sig_h      = sig_h_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_status = rsp_status_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sub2_sched.sv
// Directed bench for sub2_sched: table-driven arbitration/fill vectors plus
// hand-written sequences for completion, timeout, backpressure and reset.
module tb_sub2_sched;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid;
  logic [0:2][7:0] req_data;
  logic [2:0]      req_ready;
  logic [1:0]      cfg_mode;
  logic            sig_e;
  logic [1:0]      sig_f;
  logic [0:2][7:0] sig_g;
  logic [7:0]      sig_h [0:2];
  logic            sig_i;
  logic [1:0]      sig_j;
  logic [0:2][7:0] sig_k;
  logic [7:0]      sig_l [0:2];
  logic            rsp_valid;
  logic            rsp_ready;
  logic [0:2][7:0] rsp_data;
  logic [7:0]      rsp_tag [0:2];
  logic [1:0]      rsp_status;
  logic            timeout;

  sub2_sched #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_mode  (cfg_mode),
    .sig_e     (sig_e),
    .sig_f     (sig_f),
    .sig_g     (sig_g),
    .sig_h     (sig_h),
    .sig_i     (sig_i),
    .sig_j     (sig_j),
    .sig_k     (sig_k),
    .sig_l     (sig_l),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_status(rsp_status),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      valid;
    logic [0:2][7:0] data;
    logic [2:0]      exp_ready;
  } vec_t;

  int              total = 0;
  int              bad = 0;
  int              fcnt = 0;
  logic [0:2][7:0] exp_g;
  logic [7:0]      exp_h [0:2];
  logic [0:2][7:0] dflt;
  logic [0:2][7:0] snap_data;
  vec_t            vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] lane_of(input logic [2:0] oh);
    return oh[1] ? 2'd1 : (oh[2] ? 2'd2 : 2'd0);
  endfunction

  // One GATHER cycle: drive, check grant, record expected slot contents.
  task automatic apply(input logic [2:0] v, input logic [0:2][7:0] d, input logic [2:0] e,
                       input string nm);
    req_valid = v;
    req_data  = d;
    #1;
    chk(nm, 64'(req_ready), 64'(e));
    if (e != 3'b000) begin
      exp_g[fcnt] = d[lane_of(e)];
      exp_h[fcnt] = {6'b0, lane_of(e)};
      fcnt++;
    end
    step();
  endtask

  // Called in ISSUE; returns in the first WAIT cycle.
  task automatic issue_check(input logic [1:0] mode);
    req_valid = 3'b111;
    #1;
    chk("issue_sig_e", 64'(sig_e), 64'd1);
    chk("issue_req_ready", 64'(req_ready), 64'd0);
    chk("issue_sig_g", 64'(sig_g), 64'(exp_g));
    chk("issue_sig_h", 64'({sig_h[0], sig_h[1], sig_h[2]}),
        64'({exp_h[0], exp_h[1], exp_h[2]}));
    chk("issue_sig_f", 64'(sig_f), 64'(mode));
    req_valid = 3'b000;
    fcnt = 0;
    step();
    chk("wait_sig_e", 64'(sig_e), 64'd0);
  endtask

  task automatic quick_done();
    issue_check(cfg_mode);
    sig_i = 1'b1;
    sig_j = 2'b00;
    step();
    sig_i = 1'b0;
    chk("quick_rsp_valid", 64'(rsp_valid), 64'd1);
    step();
  endtask

  // From WAIT cycle 1: sig_i asserted on WAIT cycle k; returns in RESP.
  task automatic finish(input int k, input logic done, input logic [1:0] st,
                        input logic [0:2][7:0] rk, input logic [23:0] rl);
    for (int c = 1; c < k; c++) begin
      sig_i = 1'b0;
      step();
    end
    #1;
    chk("pre_rsp_valid", 64'(rsp_valid), 64'd0);
    sig_i = done;
    sig_j = st;
    sig_k = rk;
    sig_l[0] = rl[23:16];
    sig_l[1] = rl[15:8];
    sig_l[2] = rl[7:0];
    step();
    sig_i = 1'b0;
  endtask

  task automatic fill_from_ptr1(input string nm);
    apply(3'b111, dflt, 3'b100, {nm, "_g0"});
    apply(3'b111, dflt, 3'b001, {nm, "_g1"});
    apply(3'b111, dflt, 3'b010, {nm, "_g2"});
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({nm, "_sig_e"}, 64'(sig_e), 64'd0);
    chk({nm, "_sig_f"}, 64'(sig_f), 64'd0);
    chk({nm, "_sig_g"}, 64'(sig_g), 64'd0);
    chk({nm, "_sig_h"}, 64'({sig_h[0], sig_h[1], sig_h[2]}), 64'd0);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({nm, "_rsp_tag"}, 64'({rsp_tag[0], rsp_tag[1], rsp_tag[2]}), 64'd0);
    chk({nm, "_rsp_status"}, 64'(rsp_status), 64'd0);
    chk({nm, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dflt = {8'hA0, 8'hB1, 8'hC2};
    // ptr starts at 2; grants hand-derived from the round-robin rule.
    vecs[0]  = '{3'b111, dflt, 3'b001};
    vecs[1]  = '{3'b111, dflt, 3'b010};
    vecs[2]  = '{3'b111, dflt, 3'b100};
    vecs[3]  = '{3'b010, {8'h00, 8'h11, 8'h00}, 3'b010};
    vecs[4]  = '{3'b010, {8'h00, 8'h22, 8'h00}, 3'b010};
    vecs[5]  = '{3'b010, {8'h00, 8'h33, 8'h00}, 3'b010};
    vecs[6]  = '{3'b111, dflt, 3'b100};
    vecs[7]  = '{3'b000, dflt, 3'b000};
    vecs[8]  = '{3'b101, dflt, 3'b001};
    vecs[9]  = '{3'b101, dflt, 3'b100};
    vecs[10] = '{3'b110, dflt, 3'b010};
    vecs[11] = '{3'b011, dflt, 3'b001};

    rst = 1'b1;
    req_valid = '0;
    req_data = dflt;
    cfg_mode = 2'b11;
    sig_i = 1'b0;
    sig_j = '0;
    sig_k = '0;
    for (int k = 0; k < 3; k++) sig_l[k] = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check_zero("reset");

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].valid, vecs[i].data, vecs[i].exp_ready, $sformatf("vec%0d", i));
      if (fcnt == 3) quick_done();
    end
    // Frame 4 of the table ends with an odd count; one more 110 closes it.
    apply(3'b110, dflt, 3'b010, "vec12");
    quick_done();

    // Normal completion on the 4th WAIT cycle; ptr is 1 here.
    cfg_mode = 2'b10;
    fill_from_ptr1("norm");
    cfg_mode = 2'b01;
    issue_check(2'b10);
    finish(4, 1'b1, 2'b01, {8'hDE, 8'hAD, 8'hBE}, {8'd7, 8'd8, 8'd9});
    chk("norm_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("norm_rsp_status", 64'(rsp_status), 64'd1);
    chk("norm_rsp_data", 64'(rsp_data), 64'hDEADBE);
    chk("norm_rsp_tag", 64'({rsp_tag[0], rsp_tag[1], rsp_tag[2]}), 64'h070809);
    chk("norm_timeout", 64'(timeout), 64'd0);
    step();
    chk("norm_back_gather", 64'(rsp_valid), 64'd0);

    // Timeout: 15 WAIT cycles with sig_i low.
    rsp_ready = 1'b0;
    cfg_mode = 2'b01;
    fill_from_ptr1("tmo");
    issue_check(2'b01);
    for (int c = 1; c < 15; c++) step();
    chk("tmo_w15_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("tmo_w15_timeout", 64'(timeout), 64'd0);
    chk("tmo_w15_sig_g", 64'(sig_g), 64'(exp_g));
    chk("tmo_w15_sig_f", 64'(sig_f), 64'd1);
    step();
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_rsp_status", 64'(rsp_status), 64'd3);
    chk("tmo_rsp_data", 64'(rsp_data), 64'd0);
    chk("tmo_rsp_tag", 64'({rsp_tag[0], rsp_tag[1], rsp_tag[2]}), 64'd0);
    chk("tmo_pulse", 64'(timeout), 64'd1);
    step();
    chk("tmo_pulse_end", 64'(timeout), 64'd0);
    chk("tmo_rsp_hold", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    step();

    // Done on the 15th WAIT cycle beats the timeout.
    fill_from_ptr1("race");
    issue_check(cfg_mode);
    finish(15, 1'b1, 2'b10, {8'h01, 8'h02, 8'h03}, {8'd4, 8'd5, 8'd6});
    chk("race_rsp_status", 64'(rsp_status), 64'd2);
    chk("race_rsp_data", 64'(rsp_data), 64'h010203);
    chk("race_rsp_tag", 64'({rsp_tag[0], rsp_tag[1], rsp_tag[2]}), 64'h040506);
    chk("race_timeout", 64'(timeout), 64'd0);
    step();

    // Backpressure: rsp_ready low for 5 cycles with requests pending.
    rsp_ready = 1'b0;
    fill_from_ptr1("bp");
    issue_check(cfg_mode);
    finish(2, 1'b1, 2'b01, {8'h55, 8'h66, 8'h77}, {8'd1, 8'd2, 8'd3});
    req_valid = 3'b111;
    snap_data = {8'h55, 8'h66, 8'h77};
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_req_ready%0d", c), 64'(req_ready), 64'd0);
      chk($sformatf("bp_rsp_valid%0d", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_rsp_data%0d", c), 64'(rsp_data), 64'(snap_data));
      chk($sformatf("bp_rsp_tag%0d", c), 64'({rsp_tag[0], rsp_tag[1], rsp_tag[2]}),
          64'h010203);
      chk($sformatf("bp_rsp_status%0d", c), 64'(rsp_status), 64'd1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    fill_from_ptr1("bp_after");
    quick_done();

    // Reset during WAIT, then a fresh frame from slot 0 with lane 0 first.
    fill_from_ptr1("rstw");
    issue_check(cfg_mode);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_zero("rst_wait");
    fcnt = 0;
    apply(3'b111, dflt, 3'b001, "rst_g0");
    apply(3'b111, dflt, 3'b010, "rst_g1");
    apply(3'b111, dflt, 3'b100, "rst_g2");
    chk("rst_frame_g", 64'(exp_g), 64'hA0B1C2);
    quick_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub2_sched.md
# sub2_sched

Round-robin scheduler and sequencer sharing one `sub2` datapath instance among three byte requesters. Gathers three bytes into a frame, drives them to `sub2` as a packed array with source IDs as an unpacked array, and waits for `sub2` to complete or time out. Returns the result on a valid/ready response port. Sits directly upstream of `sub2`, between the requester lanes and the datapath.

## Interface
- `TIMEOUT`, 15: maximum WAIT cycles before a frame is aborted; legal range 1..255.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  [2:0]  per-lane request valid.
- `req_data`  in  [0:2][7:0]  per-lane byte; lane n is `req_data[n]`.
- `req_ready`  out  [2:0]  one-hot grant; a lane transfers when `req_valid[n] & req_ready[n]`.
- `cfg_mode`  in  [1:0]  mode, sampled on the third accept and forwarded on `sig_f`.
- `sig_e`  out  1  start pulse to `sub2`.
- `sig_f`  out  [1:0]  frame mode.
- `sig_g`  out  [0:2][7:0]  frame bytes; slot k is `sig_g[k]`.
- `sig_h`  out  [7:0] `[0:2]` (unpacked)  per-slot source lane ID, value `{6'b0, id}`.
- `sig_i`  in  1  `sub2` done.
- `sig_j`  in  [1:0]  `sub2` status.
- `sig_k`  in  [0:2][7:0]  `sub2` result.
- `sig_l`  in  [7:0] `[0:2]` (unpacked)  `sub2` result tags.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_data`  out  [0:2][7:0]  captured `sig_k`.
- `rsp_tag`  out  [7:0] `[0:2]` (unpacked)  captured `sig_l`.
- `rsp_status`  out  [1:0]  captured `sig_j`; `2'b11` on timeout.
- `timeout`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- FSM states: GATHER, ISSUE, WAIT, RESP. Reset state is GATHER.
- **GATHER**
  - `req_ready` is the round-robin winner among asserted `req_valid`.
  - Priority starts at lane `(ptr+1) mod 3`; `ptr` updates to the granted lane on each accept.
  - The accepted byte is written into slot `cnt` and its lane ID into ID slot `cnt`; `cnt` is 2 bits, range 0..2.
  - On the accept that makes three slots full: latch `cfg_mode` into `sig_f`, clear `cnt`, go to ISSUE.
  - A single lane may fill several slots.
- **ISSUE**
  - `sig_e`=1 for exactly this cycle.
  - `req_ready`=0.
  - Next state is WAIT.
- **WAIT**
  - `sig_e`=0; `sig_f`, `sig_g` and `sig_h` hold stable from ISSUE through the end of WAIT.
  - The 8-bit counter `wcnt` clears on entry and increments each WAIT cycle.
  - If `sig_i`=1: capture `sig_j`, `sig_k` and `sig_l` into the `rsp_*` outputs and go to RESP.
  - Otherwise, if `wcnt`==TIMEOUT-1: set `rsp_status`=`2'b11`, `rsp_data`=0 and `rsp_tag`=0; pulse `timeout`; go to RESP.
  - If `sig_i` and the timeout occur in the same cycle, `sig_i` wins: no timeout, normal capture.
- **RESP**
  - `rsp_valid`=1, with `rsp_*` stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: clear frame slots and go to GATHER.
- `sig_i` outside WAIT is ignored.
- `req_ready`=0 in every state except GATHER.
- **Reset**, including mid-frame:
  - Discard the frame; state GATHER, `cnt`=0, `ptr`=2 (lane 0 first), `wcnt`=0.
  - Every output is 0: `req_ready`, `sig_e`, `sig_f`, `sig_g`, all `sig_h` elements, `rsp_valid`, `rsp_data`, all `rsp_tag` elements, `rsp_status` and `timeout`.

## Timing
- `req_ready` is combinational from `req_valid`, `ptr` and state; there is no registered grant latency.
- `sig_e` is high the cycle after the third accept.
- WAIT begins the cycle after `sig_e`.
- `rsp_valid` rises the cycle after `sig_i` is sampled in WAIT, or the cycle after the timeout cycle.
- A timeout frame spends exactly TIMEOUT cycles in WAIT.
- `timeout` is high the same cycle `rsp_valid` first rises; it is one cycle wide.
- If `rsp_ready` is already high when `rsp_valid` rises, RESP lasts one cycle. GATHER follows and `req_ready` may assert in that cycle.
- Minimum frame period with no stalls: 3 accept cycles + ISSUE + 1 WAIT + 1 RESP = 6 cycles.
- Outputs other than `req_ready` are registered.

## Test plan
- **Round-robin fill:** lanes 0/1/2 continuously valid with 8'hA0/8'hB1/8'hC2 after reset.
  - Grants go 001, 010, 100 on consecutive cycles.
  - `sig_g`={A0,B1,C2} and `sig_h`={0,1,2}; `sig_e` pulses once, the next cycle.
- **Single lane:** only lane 1 valid, bytes 11, 22, 33.
  - Lane 1 fills all slots: `sig_g`={11,22,33}, `sig_h`={1,1,1}.
  - `ptr`=1 afterward, so the next frame's first grant goes to lane 2 when all lanes are valid.
- **Normal completion:** `sig_i` pulses on the 4th WAIT cycle with `sig_j`=01, `sig_k`={DE,AD,BE} and `sig_l`={7,8,9}.
  - `rsp_valid` rises the next cycle with the same values; `timeout` stays 0.
- **Timeout:** TIMEOUT=15, `sig_i` held low.
  - After 15 WAIT cycles: `rsp_status`=11, `rsp_data`=0, one-cycle `timeout` pulse.
  - Repeat with `sig_i`=1 on the 15th WAIT cycle: normal capture, no timeout.
- **Backpressure:** `rsp_ready` low for 5 cycles.
  - `rsp_*` stays stable and `req_ready` stays 0 throughout.
  - `rsp_ready`=1 returns the FSM to GATHER, and a grant occurs that same cycle if requests are pending.
- **Reset mid-WAIT:** `rst` high for one cycle during WAIT.
  - All outputs are 0 the next cycle.
  - A fresh frame then fills from slot 0 with lane 0 highest priority.
